// File: rtl/mod_counter_nbit.sv
// mod_counter_nbit: WIDTH-bit modulo-MODULUS up/down counter with parallel
// load, wrap or saturate at the terminal value, a combinational terminal-count
// flag for same-clock cascading, and a registered one-cycle wrap pulse.
module mod_counter_nbit #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int WRAP    = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             wrap_pulse
);

    // Highest legal count; MODULUS = 2**WIDTH makes this all ones, so the
    // wrap to 0 is plain binary rollover.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One bit wider than any legal MODULUS so the range check never truncates.
    localparam logic [32:0]      MOD_U   = 33'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic             w_at_top;
    logic             w_at_bot;
    logic             w_term;
    logic             w_load_oor;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_term_val;

    assign w_at_top   = (r_q == MAX_VAL);
    assign w_at_bot   = (r_q == '0);
    assign w_term     = up_down ? w_at_top : w_at_bot;

    // Loads at or above MODULUS clamp to the top of the range.
    assign w_load_oor = (33'(load_value) >= MOD_U);
    assign w_load_val = w_load_oor ? MAX_VAL : load_value;

    assign w_step_val = up_down ? (r_q + 1'b1) : (r_q - 1'b1);
    assign w_term_val = up_down ? '0 : MAX_VAL;

    // Terminal count is gated by the same priority as the register update, so
    // a cascaded stage only advances when this stage really rolls over.
    assign tc         = en & ~load & ~clear & w_term;

    assign q_out      = r_q;
    assign wrap_pulse = r_wrap;

    // Count register and wrap pulse: clear > load > en > hold.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_val;
            r_wrap <= 1'b0;
        end else if (en) begin
            if (w_term) begin
                if (WRAP != 0) begin
                    r_q    <= w_term_val;
                    r_wrap <= 1'b1;
                end else begin
                    r_q    <= r_q;
                    r_wrap <= 1'b0;
                end
            end else begin
                r_q    <= w_step_val;
                r_wrap <= 1'b0;
            end
        end else begin
            r_q    <= r_q;
            r_wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter_nbit.sv
module tb_mod_counter_nbit;

    logic clock;
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Per-instance stimulus: 0 default, 1 saturating MODULUS=6, 2 cascade pair,
    // 3 WIDTH=3 MODULUS=8 (binary rollover).
    logic [3:0] en_a, ud_a, ld_a, clr_a;
    logic [3:0] lv_a [4];

    logic [3:0] q0, q1, q_lo, q_hi;
    logic [2:0] q3;
    logic       tc0, tc1, tc_lo, tc_hi, tc3;
    logic       w0, w1, w_lo, w_hi, w3;

    mod_counter_nbit u_def (
        .clock(clock), .clear(clr_a[0]), .en(en_a[0]), .up_down(ud_a[0]),
        .load(ld_a[0]), .load_value(lv_a[0]),
        .q_out(q0), .tc(tc0), .wrap_pulse(w0));

    mod_counter_nbit #(.WIDTH(4), .MODULUS(6), .WRAP(0)) u_sat (
        .clock(clock), .clear(clr_a[1]), .en(en_a[1]), .up_down(ud_a[1]),
        .load(ld_a[1]), .load_value(lv_a[1]),
        .q_out(q1), .tc(tc1), .wrap_pulse(w1));

    mod_counter_nbit #(.WIDTH(4), .MODULUS(10), .WRAP(1)) u_lo (
        .clock(clock), .clear(clr_a[2]), .en(en_a[2]), .up_down(ud_a[2]),
        .load(ld_a[2]), .load_value(lv_a[2]),
        .q_out(q_lo), .tc(tc_lo), .wrap_pulse(w_lo));

    mod_counter_nbit #(.WIDTH(4), .MODULUS(6), .WRAP(1)) u_hi (
        .clock(clock), .clear(clr_a[2]), .en(tc_lo), .up_down(ud_a[2]),
        .load(ld_a[2]), .load_value(lv_a[2]),
        .q_out(q_hi), .tc(tc_hi), .wrap_pulse(w_hi));

    mod_counter_nbit #(.WIDTH(3), .MODULUS(8), .WRAP(1)) u_bin (
        .clock(clock), .clear(clr_a[3]), .en(en_a[3]), .up_down(ud_a[3]),
        .load(ld_a[3]), .load_value(lv_a[3][2:0]),
        .q_out(q3), .tc(tc3), .wrap_pulse(w3));

    // Expected response of one stimulus cycle: tc before the edge, q/wrap after.
    typedef struct {
        int          id;
        logic [15:0] q;
        logic        tc;
        logic        w;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: whenever a stimulus cycle is pending, sample tc just before the
    // edge and q/wrap just after it, and compare against the queue head.
    initial begin
        exp_t        e;
        logic        a_tc, a_w;
        logic [15:0] a_q;
        forever begin
            @(negedge clock);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0:       a_tc = tc0;
                    1:       a_tc = tc1;
                    2:       a_tc = tc_hi;
                    default: a_tc = tc3;
                endcase
                @(posedge clock);
                #1;
                case (e.id)
                    0:       begin a_q = 16'(q0);           a_w = w0;   end
                    1:       begin a_q = 16'(q1);           a_w = w1;   end
                    2:       begin a_q = 16'({q_hi, q_lo}); a_w = w_hi; end
                    default: begin a_q = 16'(q3);           a_w = w3;   end
                endcase
                chk($sformatf("tc[id%0d]", e.id), 16'(a_tc), 16'(e.tc));
                chk($sformatf("q[id%0d]", e.id), a_q, e.q);
                chk($sformatf("wrap[id%0d]", e.id), 16'(a_w), 16'(e.w));
            end
        end
    end

    // Drive one cycle of stimulus on instance id and queue its expected result.
    task automatic step(input int id, input logic en, input logic ud, input logic ld,
                        input logic [3:0] lv, input logic clr,
                        input logic [15:0] eq, input logic etc, input logic ew);
        exp_t e;
        @(negedge clock);
        en_a = '0; ld_a = '0; clr_a = '0;
        en_a[id] = en; ud_a[id] = ud; ld_a[id] = ld; clr_a[id] = clr; lv_a[id] = lv;
        e.id = id; e.q = eq; e.tc = etc; e.w = ew;
        sb.push_back(e);
    endtask

    initial begin
        int pre;
        en_a = '0; ud_a = '0; ld_a = '0; clr_a = '0;
        for (int i = 0; i < 4; i++) lv_a[i] = '0;

        // Default instance: clear with en high, then up wrap 1..9,0,1,2.
        step(0, 1, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 12; k++)
            step(0, 1, 1, 0, 0, 0, 16'(k % 10), (k == 10), (k == 10));
        // Down wrap from 0: 9, 8, 7.
        step(0, 0, 1, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 9, 1, 1);
        step(0, 1, 0, 0, 0, 0, 8, 0, 0);
        step(0, 1, 0, 0, 0, 0, 7, 0, 0);
        // Clear with load at 7: clear wins.
        step(0, 1, 0, 1, 3, 1, 0, 0, 0);
        // Loads: 6 with en=0, 13 clamps to 9, load at terminal keeps tc low.
        step(0, 0, 1, 1, 6, 0, 6, 0, 0);
        step(0, 1, 1, 1, 13, 0, 9, 0, 0);
        step(0, 1, 1, 1, 5, 0, 5, 0, 0);
        // Hold, then direction changes take effect immediately.
        step(0, 0, 1, 0, 0, 0, 5, 0, 0);
        step(0, 1, 0, 0, 0, 0, 4, 0, 0);
        step(0, 1, 1, 0, 0, 0, 5, 0, 0);
        // Load 0, down wrap, hold (pulse drops), up wrap from 9.
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 9, 1, 1);
        step(0, 0, 0, 0, 0, 0, 9, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 1, 1);

        // Saturating MODULUS=6: 8 up edges stop at 5, never pulse.
        step(1, 0, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            step(1, 1, 1, 0, 0, 0, 16'((k < 5) ? k : 5), (k >= 6), 0);
        step(1, 0, 1, 1, 15, 0, 5, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0, 1, 0, 0);

        // Cascade 10 x 6: 59 edges read 5:9, edge 60 reads 0:0.
        step(2, 0, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            pre = k - 1;
            step(2, 1, 1, 0, 0, 0, 16'((((k % 60) / 10) << 4) | (k % 10)),
                 (pre == 59), (k == 60));
        end

        // MODULUS = 2**WIDTH: natural rollover 7 -> 0 with tc/pulse.
        step(3, 0, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 9; k++)
            step(3, 1, 1, 0, 0, 0, 16'(k % 8), (k == 8), (k == 8));
        step(3, 1, 0, 1, 4'd5, 0, 5, 0, 0);

        // Release stimulus and let the monitor drain, bounded.
        @(negedge clock);
        en_a = '0; ld_a = '0; clr_a = '0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mod_counter_nbit.md
MOD_COUNTER_NBIT -- requirements
Module: mod_counter_nbit

Interface
REQ-001 Parameter: WIDTH, default 4, count register width in bits; legal range 1..16.
REQ-002 Parameter: MODULUS, default 10, count sequence length; legal range 2..2**WIDTH.
REQ-003 Parameter: WRAP, default 1; 1 = wrap at terminal value, 0 = saturate at terminal value.
REQ-004 Port: clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port: clear, input, 1, synchronous active-high reset.
REQ-006 Port: en, input, 1, count enable; also the enable input for cascading.
REQ-007 Port: up_down, input, 1, count direction; 1 = up, 0 = down.
REQ-008 Port: load, input, 1, synchronous parallel-load strobe.
REQ-009 Port: load_value, input, WIDTH, value used when load is asserted.
REQ-010 Port: q_out, output, WIDTH, current count; a registered output.
REQ-011 Port: tc, output, 1, terminal-count flag; combinational; drives en of the next stage.
REQ-012 Port: wrap_pulse, output, 1, registered one-cycle pulse flagging that a wrap occurred.

Function
REQ-013 Priority at each rising clock edge: clear > load > en > hold.
REQ-014 Load: when load=1 and clear=0, q_out SHALL become load_value on the next edge, regardless of en.
REQ-015 Out-of-range load: if load_value >= MODULUS, q_out SHALL become MODULUS-1.
REQ-016 Count up: when en=1, up_down=1 and q_out < MODULUS-1, q_out SHALL increment by 1.
REQ-017 Count down: when en=1, up_down=0 and q_out > 0, q_out SHALL decrement by 1.
REQ-018 Up terminal, WRAP=1: at q_out = MODULUS-1, q_out SHALL go to 0.
REQ-019 Down terminal, WRAP=1: at q_out = 0, q_out SHALL go to MODULUS-1.
REQ-020 Terminal, WRAP=0: at the terminal value for the current direction, q_out SHALL hold.
REQ-021 Hold: when en=0, load=0 and clear=0, q_out SHALL hold.
REQ-022 tc SHALL equal en AND NOT load AND NOT clear AND the terminal condition.
REQ-023 Terminal condition: (up_down=1 and q_out=MODULUS-1) or (up_down=0 and q_out=0).
REQ-024 tc SHALL be combinational, with zero latency, so stages can be cascaded by connecting tc to the next stage's en, all on the same clock.
REQ-025 wrap_pulse SHALL be 1 for exactly one cycle after each edge on which a REQ-018/019 wrap occurred.
REQ-026 wrap_pulse SHALL always be 0 when WRAP=0.
REQ-027 Direction change: a change of up_down SHALL take effect on the same edge, with no dead cycle.
REQ-028 q_out SHALL never hold a value >= MODULUS after the first edge following reset or load.
REQ-029 Arithmetic SHALL be WIDTH-bit unsigned.
REQ-030 When MODULUS = 2**WIDTH, the wrap SHALL be natural binary rollover, with identical tc and wrap_pulse behaviour.

Reset
REQ-031 clear=1 at a rising edge SHALL set q_out=0 and wrap_pulse=0 on that edge.
REQ-032 clear SHALL override load and en.
REQ-033 While clear=1, tc SHALL be 0.
REQ-034 Asserting clear mid-count SHALL abort the sequence, with no wrap_pulse generated.
REQ-035 Release of clear SHALL resume counting from 0 on the first edge with en=1.
REQ-036 No other register SHALL exist outside the reset domain.

Verification
REQ-037 Up wrap (defaults, WRAP=1): clear, then en=1, up_down=1 for 12 edges -> q_out 1..9, 0, 1, 2.
  - tc=1 only while q_out=9.
  - wrap_pulse=1 for the single cycle in which q_out=0.
REQ-038 Down wrap (defaults): from q_out=0 with en=1, up_down=0, apply 3 edges -> q_out 9, 8, 7.
  - tc=1 while q_out=0.
  - wrap_pulse=1 after the first edge.
REQ-039 Load: apply load=1, load_value=6 with en=0 -> q_out=6.
  - Then apply load_value=13 -> q_out=9.
  - tc=0 during both loads even when en=1.
REQ-040 Saturate (WRAP=0, MODULUS=6): with en=1, up_down=1, from 0 apply 8 edges -> q_out stops at 5.
  - tc=1 at 5.
  - wrap_pulse stays 0.
REQ-041 Cascade: two instances (MODULUS=10 low, 6 high), with tc_low driving en_high -> after 59 edges the pair reads 5:9; on edge 60 both read 0.
REQ-042 Reset mid-operation: at q_out=7 assert clear together with load=1, load_value=3 -> q_out=0, wrap_pulse=0, tc=0.
